instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   Feeds the instruction decoder: holds the PC and fetches 16-bit words from instruction memory.
//   Presents each word plus its PC to the decoder.
//   Samples the decoder's halt and branch outcome to choose the next PC.
//   Sits between the instruction memory and the decoder.
//   Multi-cycle: one instruction is in flight at a time, and memory may take a variable number of cycles.
// PARAMETERS
//   RESET_PC     16'h0000  PC loaded on reset
//   MEM_TIMEOUT  15        max WAIT cycles without imem_rdy before fetch error (1..255)
// PORTS
//   clk         in   1   system clock; all state on rising edge
//   rst_n       in   1   asynchronous, active-low reset
//   imem_re     out  1   memory read request, one-cycle pulse
//   imem_addr   out  16  word address of request (= pc)
//   imem_rdata  in   16  returned instruction word
//   imem_rdy    in   1   imem_rdata valid this cycle
//   instr       out  16  instruction to decoder (registered)
//   pc          out  16  PC of instr (registered)
//   instr_vld   out  1   instr/pc valid for decode/execute
//   stall       in   1   backend not ready; holds ISSUE
//   hlt         in   1   decoder: instr is HLT
//   br_taken    in   1   branch/jump resolved taken for instr
//   br_target   in   16  target PC when br_taken
//   halted      out  1   fetch stopped on HLT
//   fetch_err   out  1   sticky memory-timeout error
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     state=IDLE, pc=RESET_PC, instr=16'h0000, instr_vld=0, imem_re=0.
//     halted=0, fetch_err=0, wait counter=0.
//   IDLE:
//     Exactly one cycle after rst_n deasserts, then go to REQ.
//   REQ:
//     imem_re=1 and imem_addr=pc for this one cycle; clear counter; go to WAIT.
//   WAIT:
//     imem_re=0.
//     If imem_rdy: instr<=imem_rdata, go to ISSUE.
//     Else counter+1; when counter reaches MEM_TIMEOUT, go to ERR.
//     imem_rdy arriving in the same cycle as the timeout wins (data accepted).
//     imem_rdy in any state other than WAIT is ignored.
//   ISSUE:
//     instr_vld=1. hlt, br_taken and br_target are sampled here only.
//     If stall=1: stay in ISSUE; instr, pc and instr_vld are held.
//     Else if hlt=1: go to HALT; pc unchanged. hlt wins over br_taken.
//     Else: pc <= br_taken ? br_target : pc+1, then go to REQ.
//     pc+1 is modulo 2^16 (16'hFFFF -> 16'h0000).
//   HALT:
//     halted=1, instr_vld=0, no requests; only reset exits.
//   ERR:
//     fetch_err=1, halted=1, instr_vld=0, no requests; only reset exits.
//   Outputs:
//     imem_addr always equals pc.
//     instr_vld is high only in ISSUE.
//     All outputs are registered or decoded from state; there are no combinational paths from inputs.
//   Latency:
//     REQ -> WAIT(n>=1) -> ISSUE.
//     Minimum 3 cycles per instruction with zero-wait memory (rdy in first WAIT cycle).
//   Reset mid-fetch:
//     State returns to IDLE immediately.
//     A late imem_rdy for the aborted request is ignored.
//     The first request after reset is to RESET_PC.
// TESTING
//   1. Reset, zero-wait memory returning 16'h0123 at every address, no branches:
//      imem_addr sequence 0,1,2,3; instr_vld pulse every 3rd cycle; pc matches.
//   2. Branch: at pc=16'h0004 drive br_taken=1, br_target=16'h0010:
//      next imem_re has addr 16'h0010.
//      Repeat with br_taken=0: next addr 16'h0005.
//   3. Halt: at pc=16'h0002 drive hlt=1 together with br_taken=1:
//      halted=1, pc stays 16'h0002, no further imem_re, instr_vld=0.
//   4. Stall and wait states:
//      stall=1 for 4 cycles in ISSUE holds instr and pc with instr_vld=1.
//      Memory with 5-cycle latency is accepted with no error.
//   5. Timeout, MEM_TIMEOUT=15:
//      withholding imem_rdy sets fetch_err=1 and halted=1 after 15 WAIT cycles.
//      rdy exactly on cycle 15 is accepted instead.
//   6. Wrap and reset:
//      RESET_PC=16'hFFFF: second fetch goes to 16'h0000.
//      Assert rst_n=0 mid-WAIT, then release: late imem_rdy is ignored and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch unit sitting between instruction memory and the decoder.
//   Holds the PC and issues one 16-bit word fetch at a time. The memory may take
//   a variable number of cycles to answer. The fetched word and its PC are then
//   presented to the decoder. The decoder's halt and branch outcome, sampled
//   while the word is presented, select the next PC.
//
//   Sequence per instruction: IDLE (once after reset) -> REQ -> WAIT (1..n) ->
//   ISSUE -> REQ ...  HALT and ERR are terminal until reset.
//
// Parameters
//   RESET_PC     PC loaded on reset
//   MEM_TIMEOUT  WAIT cycles without imem_rdy before a fetch error (1..255)
//
// Ports
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   imem_re      read request, one-cycle pulse in REQ
//   imem_addr    word address of the request (always equals pc)
//   imem_rdata   returned instruction word
//   imem_rdy     imem_rdata valid this cycle (honoured only in WAIT)
//   instr, pc    instruction and its PC presented to the decoder
//   instr_vld    instr/pc valid (high only in ISSUE)
//   stall        backend not ready, holds ISSUE
//   hlt          decoder reports instr is HLT
//   br_taken     branch/jump resolved taken for instr
//   br_target    target PC when br_taken
//   halted       fetch stopped (HLT or error)
//   fetch_err    sticky memory-timeout error
// ----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_re,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_rdy,
  output logic [15:0] instr,
  output logic [15:0] pc,
  output logic        instr_vld,
  input  logic        stall,
  input  logic        hlt,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        halted,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StIssue,
    StHalt,
    StErr
  } state_e;

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;

  logic        imem_re_q;
  logic        instr_vld_q;
  logic        halted_q;
  logic        fetch_err_q;

  // Next-state logic. Inputs only influence registered state, so every output
  // below is a flop and there is no combinational input-to-output path.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 8'd1;

    case (state_q)
      StIdle: begin
        state_d = StReq;
      end

      StReq: begin
        cnt_d   = 8'd0;
        state_d = StWait;
      end

      StWait: begin
        // Data arriving on the timeout cycle itself is still accepted.
        if (imem_rdy) begin
          instr_d = imem_rdata;
          state_d = StIssue;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TimeoutCnt) begin
            state_d = StErr;
          end
        end
      end

      StIssue: begin
        // stall dominates; hlt dominates a simultaneous taken branch.
        if (!stall) begin
          if (hlt) begin
            state_d = StHalt;
          end else begin
            pc_d    = br_taken ? br_target : (pc_q + 16'd1);
            state_d = StReq;
          end
        end
      end

      StHalt: begin
        state_d = StHalt;
      end

      StErr: begin
        state_d = StErr;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs. Outputs are loaded from the next state so
  // that they line up with state_q in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      instr_q     <= 16'h0000;
      cnt_q       <= 8'd0;
      imem_re_q   <= 1'b0;
      instr_vld_q <= 1'b0;
      halted_q    <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      cnt_q       <= cnt_d;
      imem_re_q   <= (state_d == StReq);
      instr_vld_q <= (state_d == StIssue);
      halted_q    <= (state_d == StHalt) || (state_d == StErr);
      fetch_err_q <= (state_d == StErr);
    end
  end

  assign imem_re   = imem_re_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign instr_vld = instr_vld_q;
  assign halted    = halted_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed plus randomized bench for instr_fetch. The bench plays the memory
//   and decoder and predicts each fetch address from a program-counter model:
//   next = halt ? pc : taken ? target : pc + 1 (mod 2^16).
//   A second instance with RESET_PC=16'hFFFF shares all inputs and is checked
//   only for the reset-vector wrap.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_rdata;
  logic        imem_rdy;
  logic        stall;
  logic        hlt;
  logic        br_taken;
  logic [15:0] br_target;

  logic        imem_re;
  logic [15:0] imem_addr;
  logic [15:0] instr;
  logic [15:0] pc;
  logic        instr_vld;
  logic        halted;
  logic        fetch_err;

  logic        w_imem_re;
  logic [15:0] w_imem_addr;
  logic [15:0] w_instr;
  logic [15:0] w_pc;
  logic        w_instr_vld;
  logic        w_halted;
  logic        w_fetch_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC   (16'h0000),
    .MEM_TIMEOUT(15)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_re   (imem_re),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .imem_rdy  (imem_rdy),
    .instr     (instr),
    .pc        (pc),
    .instr_vld (instr_vld),
    .stall     (stall),
    .hlt       (hlt),
    .br_taken  (br_taken),
    .br_target (br_target),
    .halted    (halted),
    .fetch_err (fetch_err)
  );

  instr_fetch #(
    .RESET_PC   (16'hFFFF),
    .MEM_TIMEOUT(15)
  ) u_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_re   (w_imem_re),
    .imem_addr (w_imem_addr),
    .imem_rdata(imem_rdata),
    .imem_rdy  (imem_rdy),
    .instr     (w_instr),
    .pc        (w_pc),
    .instr_vld (w_instr_vld),
    .stall     (stall),
    .hlt       (hlt),
    .br_taken  (br_taken),
    .br_target (br_target),
    .halted    (w_halted),
    .fetch_err (w_fetch_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Asserts reset, checks the reset values, releases it and checks that the
  // first request follows exactly one idle cycle.
  task automatic do_reset(input logic [15:0] rst_pc);
    @(negedge clk);
    rst_n    = 1'b0;
    imem_rdy = 1'b0;
    stall    = 1'b0;
    hlt      = 1'b0;
    br_taken = 1'b0;
    #1;
    chk16("rst_pc", pc, rst_pc);
    chk16("rst_instr", instr, 16'h0000);
    chk1("rst_vld", instr_vld, 1'b0);
    chk1("rst_re", imem_re, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_err", fetch_err, 1'b0);
    tick();
    rst_n = 1'b1;
    chk1("idle_re", imem_re, 1'b0);
    tick();
    chk1("first_req_re", imem_re, 1'b1);
    chk16("first_req_addr", imem_addr, rst_pc);
  endtask

  // One complete fetch: request at exp_addr, rdy on WAIT cycle lat, stalls
  // cycles of stall in ISSUE, then the given decoder outcome.
  task automatic do_fetch(input logic [15:0] exp_addr, input int unsigned lat,
                          input logic [15:0] data, input int unsigned stalls,
                          input logic h, input logic b, input logic [15:0] tgt,
                          output logic [15:0] nxt);
    int unsigned guard = 0;
    while (!imem_re && guard < 8) begin
      tick();
      guard++;
    end
    chk1("req_seen", imem_re, 1'b1);
    chk16("req_addr", imem_addr, exp_addr);
    chk1("req_vld", instr_vld, 1'b0);
    tick();
    for (int i = 1; i < int'(lat); i++) begin
      // Decoder inputs are noise outside ISSUE and must be ignored.
      hlt      = 1'($urandom);
      br_taken = 1'($urandom);
      chk1("wait_re", imem_re, 1'b0);
      chk1("wait_vld", instr_vld, 1'b0);
      tick();
    end
    hlt        = 1'b0;
    br_taken   = 1'b0;
    imem_rdy   = 1'b1;
    imem_rdata = data;
    tick();
    imem_rdy   = 1'b0;
    imem_rdata = 16'($urandom);
    chk1("issue_vld", instr_vld, 1'b1);
    chk16("issue_instr", instr, data);
    chk16("issue_pc", pc, exp_addr);
    chk1("issue_err", fetch_err, 1'b0);
    for (int s = 0; s < int'(stalls); s++) begin
      stall    = 1'b1;
      hlt      = 1'b1;
      br_taken = 1'b1;
      tick();
      chk1("stall_vld", instr_vld, 1'b1);
      chk16("stall_instr", instr, data);
      chk16("stall_pc", pc, exp_addr);
    end
    stall     = 1'b0;
    hlt       = h;
    br_taken  = b;
    br_target = tgt;
    tick();
    hlt      = 1'b0;
    br_taken = 1'b0;
    nxt = h ? exp_addr : (b ? tgt : exp_addr + 16'd1);
    if (h) begin
      chk1("halt_halted", halted, 1'b1);
      chk1("halt_vld", instr_vld, 1'b0);
      chk16("halt_pc", pc, exp_addr);
      chk1("halt_re", imem_re, 1'b0);
    end else begin
      chk1("next_re", imem_re, 1'b1);
      chk16("next_addr", imem_addr, nxt);
      chk1("next_vld", instr_vld, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] npc;
    logic [15:0] mpc;
    rst_n      = 1'b1;
    imem_rdata = 16'h0000;
    imem_rdy   = 1'b0;
    stall      = 1'b0;
    hlt        = 1'b0;
    br_taken   = 1'b0;
    br_target  = 16'h0000;

    // Zero-wait sequential fetches, then taken branch at 0x0004.
    do_reset(16'h0000);
    npc = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      do_fetch(npc, 1, 16'h0123, 0, 1'b0, 1'b0, 16'h0000, npc);
    end
    do_fetch(npc, 1, 16'h0123, 0, 1'b0, 1'b1, 16'h0010, npc);
    chk16("branch_taken_addr", imem_addr, 16'h0010);

    // Same path, branch not taken at 0x0004.
    do_reset(16'h0000);
    npc = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      do_fetch(npc, 1, 16'h0123, 0, 1'b0, 1'b0, 16'h0010, npc);
    end
    chk16("branch_not_taken_addr", imem_addr, 16'h0005);

    // Halt at 0x0002 with a simultaneous taken branch.
    do_reset(16'h0000);
    npc = 16'h0000;
    do_fetch(npc, 1, 16'h1111, 0, 1'b0, 1'b0, 16'h0000, npc);
    do_fetch(npc, 1, 16'h2222, 0, 1'b0, 1'b0, 16'h0000, npc);
    do_fetch(npc, 1, 16'h3333, 0, 1'b1, 1'b1, 16'h0077, npc);
    for (int k = 0; k < 5; k++) begin
      imem_rdy = 1'b1;
      tick();
      chk1("halted_no_re", imem_re, 1'b0);
      chk1("halted_stay", halted, 1'b1);
      chk16("halted_pc", pc, 16'h0002);
    end
    imem_rdy = 1'b0;

    // Stall for 4 cycles and a 5-cycle memory, then rdy on the timeout cycle.
    do_reset(16'h0000);
    npc = 16'h0000;
    do_fetch(npc, 5, 16'hA5A5, 4, 1'b0, 1'b0, 16'h0000, npc);
    do_fetch(npc, 15, 16'h5A5A, 0, 1'b0, 1'b0, 16'h0000, npc);
    chk1("late_rdy_no_err", fetch_err, 1'b0);

    // Memory never answers: error after 15 WAIT cycles.
    do_reset(16'h0000);
    tick();
    for (int k = 0; k < 14; k++) begin
      tick();
      chk1("to_wait_no_err", fetch_err, 1'b0);
    end
    tick();
    chk1("to_err", fetch_err, 1'b1);
    chk1("to_halted", halted, 1'b1);
    chk1("to_vld", instr_vld, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("to_no_re", imem_re, 1'b0);
      chk1("to_sticky", fetch_err, 1'b1);
    end

    // Reset vector 0xFFFF wraps to 0x0000 on the second fetch.
    do_reset(16'h0000);
    chk16("wrap_first_addr", w_imem_addr, 16'hFFFF);
    npc = 16'h0000;
    do_fetch(npc, 2, 16'h0BAD, 0, 1'b0, 1'b0, 16'h0000, npc);
    chk16("wrap_second_addr", w_imem_addr, 16'h0000);
    chk1("wrap_second_re", w_imem_re, 1'b1);

    // Reset in the middle of WAIT; the late rdy must not be taken.
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk16("midwait_rst_pc", pc, 16'h0000);
    chk16("midwait_rst_wpc", w_pc, 16'hFFFF);
    chk1("midwait_rst_vld", instr_vld, 1'b0);
    tick();
    rst_n      = 1'b1;
    imem_rdy   = 1'b1;
    imem_rdata = 16'hDEAD;
    chk1("midwait_idle_vld", instr_vld, 1'b0);
    tick();
    chk1("midwait_req_re", imem_re, 1'b1);
    chk16("midwait_req_addr", imem_addr, 16'h0000);
    chk16("midwait_req_waddr", w_imem_addr, 16'hFFFF);
    tick();
    imem_rdy = 1'b0;
    tick();
    chk1("midwait_ignored_vld", instr_vld, 1'b0);
    chk16("midwait_ignored_instr", instr, 16'h0000);
    imem_rdy   = 1'b1;
    imem_rdata = 16'h4242;
    tick();
    imem_rdy = 1'b0;
    chk1("midwait_issue_vld", instr_vld, 1'b1);
    chk16("midwait_issue_instr", instr, 16'h4242);
    chk16("midwait_issue_pc", pc, 16'h0000);

    // Randomized program flow against the PC model.
    do_reset(16'h0000);
    mpc = 16'h0000;
    for (int k = 0; k < 24; k++) begin
      int unsigned lat;
      int unsigned stl;
      logic        b;
      logic [15:0] d;
      logic [15:0] t;
      lat = $urandom_range(1, 6);
      stl = $urandom_range(0, 2);
      b   = ($urandom_range(0, 3) == 0);
      d   = 16'($urandom);
      t   = 16'($urandom);
      do_fetch(mpc, lat, d, stl, 1'b0, b, t, npc);
      mpc = b ? t : mpc + 16'd1;
      chk16("rand_model_pc", npc, mpc);
    end
    do_fetch(mpc, 2, 16'h7777, 0, 1'b0, 1'b1, 16'hFFFF, npc);
    do_fetch(16'hFFFF, 1, 16'h8888, 1, 1'b0, 1'b0, 16'h0000, npc);
    chk16("rand_wrap_addr", imem_addr, 16'h0000);
    do_fetch(16'h0000, 3, 16'h9999, 0, 1'b1, 1'b0, 16'h0000, npc);
    chk1("rand_final_halt", halted, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
